// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard and forwarding control.
// Holds the FSM state codes, forwarding-select codes and register address width.
package mips_pipe_pkg;

  localparam int REG_AW = 5;
  localparam int MDU_CW = 6;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MDU_BUSY = 1'b1;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctl_t;

  // Counter preload for an op that occupies the EX stage for 'cycles' cycles.
  function automatic logic [MDU_CW-1:0] mdu_load(input int cycles);
    return MDU_CW'(cycles - 1);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one ALU source: EX/MEM result wins over MEM/WB,
// and register 0 never forwards.
module pipe_fwd_unit
  import mips_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] ex_src,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src);
  assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_src);

  always_comb begin
    fwd_sel = FWD_NONE;
    if (mem_hit) begin
      fwd_sel = FWD_MEM;
    end else if (wb_hit) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multiply/divide stalls, branch flush,
// ALU operand forwarding and multi-cycle MDU occupancy tracking.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_mdu,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_mdu_start,
  input  logic              ex_mdu_div,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy
);

  localparam logic [MDU_CW-1:0] MULT_LOAD = mdu_load(MULT_CYCLES);
  localparam logic [MDU_CW-1:0] DIV_LOAD  = mdu_load(DIV_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [MDU_CW-1:0] cnt_q, cnt_d;
  logic [MDU_CW-1:0] issue_load;

  // ex_regwrite is part of the EX-stage bundle but only ex_memread gates hazards.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue_load = ex_mdu_div ? DIV_LOAD : MULT_LOAD;
    if (state_q == ST_IDLE) begin
      // A single-cycle op finishes in its issue cycle and never occupies the unit.
      if (ex_mdu_start && (issue_load != '0)) begin
        state_d = ST_MDU_BUSY;
        cnt_d   = issue_load;
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - MDU_CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdu_busy = (state_q == ST_MDU_BUSY);

  logic load_use;
  logic mdu_hazard;
  logic stall;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign mdu_hazard = mdu_busy && id_is_mdu;
  assign stall      = load_use || mdu_hazard;

  pipe_ctl_t ctl;

  // A taken branch squashes the stalled instruction anyway, so it wins over a stall.
  always_comb begin
    ctl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    if (!RST_N) begin
      ctl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
    end else if (ex_branch_taken) begin
      ctl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    end else if (stall) begin
      ctl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_bubble = ctl.idex_bubble;

  reg_addr_t  ex_src [2];
  logic [1:0] fwd_sel [2];

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    pipe_fwd_unit u_fwd (
      .ex_src       (ex_src[gi]),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .fwd_sel      (fwd_sel[gi])
    );
  end

  assign fwd_a = RST_N ? fwd_sel[0] : FWD_NONE;
  assign fwd_b = RST_N ? fwd_sel[1] : FWD_NONE;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl with a queue scoreboard;
// a second instance uses single-cycle multiply and two-cycle divide.
module tb_pipe_hazard_ctrl;

  localparam int D0_MULT = 4;
  localparam int D0_DIV  = 32;
  localparam int D1_MULT = 1;
  localparam int D1_DIV  = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, id_is_mdu;
  logic       ex_memread, ex_regwrite, ex_branch_taken, ex_mdu_start, ex_mdu_div;
  logic       mem_regwrite, wb_regwrite;

  logic       pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_write1, ifid_write1, ifid_flush1, idex_bubble1, mdu_busy1;
  logic [1:0] fwd_a1, fwd_b1;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MULT_CYCLES(D0_MULT), .DIV_CYCLES(D0_DIV)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_mdu(id_is_mdu), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy)
  );

  pipe_hazard_ctrl #(.MULT_CYCLES(D1_MULT), .DIV_CYCLES(D1_DIV)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_mdu(id_is_mdu), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mdu_busy(mdu_busy1)
  );

  typedef struct packed {
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       busy;
    logic       busy1;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;
  int   busy_left  = 0;   // remaining busy cycles of the default instance
  int   busy_left1 = 0;   // same for the short-latency instance

  // Cycles the unit reports busy after issuing an op of n cycles.
  function automatic int occupancy(input int n);
    return (n <= 1) ? 0 : n;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (!RST_N) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge();
    if (!RST_N) begin
      busy_left  = 0;
      busy_left1 = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      else if (ex_mdu_start) busy_left = occupancy(ex_mdu_div ? D0_DIV : D0_MULT);
      if (busy_left1 > 0) busy_left1--;
      else if (ex_mdu_start) busy_left1 = occupancy(ex_mdu_div ? D1_DIV : D1_MULT);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    RST_N = 1'b1;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_mdu = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; ex_mdu_div = 1'b0;
    mem_regwrite = 1'b0; mem_rd = '0; wb_regwrite = 1'b0; wb_rd = '0;
  endtask

  task automatic rand_inputs();
    RST_N           = 1'($urandom_range(0, 59) != 0);
    id_rs           = 5'($urandom_range(0, 3));
    id_rt           = 5'($urandom_range(0, 3));
    id_use_rs       = 1'($urandom_range(0, 1));
    id_use_rt       = 1'($urandom_range(0, 1));
    id_is_mdu       = 1'($urandom_range(0, 3) == 0);
    ex_rs           = 5'($urandom_range(0, 3));
    ex_rt           = 5'($urandom_range(0, 3));
    ex_rd           = 5'($urandom_range(0, 3));
    ex_memread      = 1'($urandom_range(0, 1));
    ex_regwrite     = 1'($urandom_range(0, 1));
    ex_branch_taken = 1'($urandom_range(0, 7) == 0);
    ex_mdu_start    = 1'($urandom_range(0, 7) == 0);
    ex_mdu_div      = 1'($urandom_range(0, 3) == 0);
    mem_regwrite    = 1'($urandom_range(0, 1));
    mem_rd          = 5'($urandom_range(0, 3));
    wb_regwrite     = 1'($urandom_range(0, 1));
    wb_rd           = 5'($urandom_range(0, 3));
  endtask

  task automatic push_exp();
    obs_t e;
    logic lu, st;
    if (!RST_N) begin
      busy_left  = 0;
      busy_left1 = 0;
    end
    e.busy  = (busy_left > 0);
    e.busy1 = (busy_left1 > 0);
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    st = lu || (e.busy && id_is_mdu);
    if (!RST_N)               {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble} = 4'b0011;
    else if (ex_branch_taken) {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble} = 4'b1111;
    else if (st)              {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble} = 4'b0001;
    else                      {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble} = 4'b1100;
    e.fwd_a = fwd_ref(ex_rs);
    e.fwd_b = fwd_ref(ex_rt);
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, mdu_busy, mdu_busy1};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL txn %0d outputs(pc,ifid,flush,bubble,fa,fb,busy,busy1): got %b required %b",
                 txn, a, e);
      end else begin
        $display("[TB] txn %0d ok %b", txn, a);
      end
      txn++;
    end
  end

  initial begin
    clear_inputs();
    RST_N = 1'b0;

    // Reset state, then first idle cycle after release.
    next_cycle(); clear_inputs(); RST_N = 1'b0; ex_mdu_start = 1'b1; push_exp();
    next_cycle(); clear_inputs(); push_exp();

    // Load-use stall and its release; r0 load never stalls.
    next_cycle(); clear_inputs(); ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; push_exp();
    next_cycle(); clear_inputs(); ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; push_exp();
    next_cycle(); clear_inputs(); ex_memread = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; push_exp();
    next_cycle(); clear_inputs(); ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; push_exp();

    // Branch overrides a load-use stall.
    next_cycle(); clear_inputs(); ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    ex_branch_taken = 1'b1; push_exp();

    // Forwarding priority and register 0.
    next_cycle(); clear_inputs(); ex_rs = 5'd5; ex_rt = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1; push_exp();
    next_cycle(); clear_inputs(); ex_rs = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; push_exp();
    next_cycle(); clear_inputs(); mem_regwrite = 1'b1; wb_regwrite = 1'b1; push_exp();

    // Divide issue followed by MDU instructions held in ID.
    next_cycle(); clear_inputs(); ex_mdu_start = 1'b1; ex_mdu_div = 1'b1; id_is_mdu = 1'b1; push_exp();
    for (int i = 0; i < 34; i++) begin
      next_cycle(); clear_inputs(); id_is_mdu = 1'b1; ex_branch_taken = 1'(i == 5);
      ex_mdu_start = 1'(i == 10); push_exp();
    end

    // Reset asserted between edges on the second busy cycle of a multiply.
    next_cycle(); clear_inputs(); ex_mdu_start = 1'b1; push_exp();
    next_cycle(); clear_inputs(); id_is_mdu = 1'b1; push_exp();
    next_cycle(); clear_inputs(); id_is_mdu = 1'b1; RST_N = 1'b0; push_exp();
    next_cycle(); clear_inputs(); id_is_mdu = 1'b1; RST_N = 1'b0; push_exp();
    next_cycle(); clear_inputs(); id_is_mdu = 1'b1; push_exp();

    for (int i = 0; i < 400; i++) begin
      next_cycle(); rand_inputs(); push_exp();
    end

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
